// File: rtl/mct_sequencer.sv
// mct_sequencer: one-hot time-pulse generator and MCT counter with RUPT insertion at instruction boundaries
module mct_sequencer #(
  parameter int TP_PER_MCT = 12,
  parameter int RUPT_MCT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic                  extracode,
  output logic                  op_ready,
  input  logic                  irq_req,
  input  logic                  irq_inhibit,
  output logic                  irq_ack,
  output logic [TP_PER_MCT-1:0] tp,
  output logic [2:0]            mct_idx,
  output logic [1:0]            seq_state,
  output logic                  instr_done
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RUPT = 2'd2} state_t;
  localparam logic [TP_PER_MCT-1:0] T01 = TP_PER_MCT'(1);
  state_t state, state_nx;
  logic [TP_PER_MCT-1:0] tp_nx;
  logic [2:0] mct_nx, cnt, cnt_nx, op_cnt;
  logic boundary, take_irq;
  assign op_cnt = (op == 3'b000) ? (extracode ? 3'd2 : 3'd1) :
                  (op == 3'b001 && extracode) ? 3'd6 :
                  (op == 3'b111 && extracode) ? 3'd3 : 3'd2;
  assign boundary   = (state == IDLE) || (tp[TP_PER_MCT-1] && mct_idx == cnt - 3'd1);
  assign take_irq   = boundary & run & irq_req & ~irq_inhibit & (state != RUPT);
  assign op_ready   = boundary & ~take_irq;
  assign irq_ack    = take_irq;
  assign instr_done = run & boundary & (state == EXEC);
  assign seq_state  = state;
  always_comb begin
    state_nx = state;
    tp_nx    = tp;
    mct_nx   = mct_idx;
    cnt_nx   = cnt;
    if (run && boundary) begin
      state_nx = take_irq ? RUPT : op_valid ? EXEC : IDLE;
      cnt_nx   = take_irq ? 3'(RUPT_MCT) : op_valid ? op_cnt : cnt;
      tp_nx    = (take_irq || op_valid) ? T01 : '0;
      mct_nx   = 3'd0;
    end else if (run) begin
      tp_nx  = tp[TP_PER_MCT-1] ? T01 : {tp[TP_PER_MCT-2:0], 1'b0};
      mct_nx = tp[TP_PER_MCT-1] ? mct_idx + 3'd1 : mct_idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tp      <= '0;
      mct_idx <= 3'd0;
      cnt     <= 3'd1;
    end else begin
      state   <= state_nx;
      tp      <= tp_nx;
      mct_idx <= mct_nx;
      cnt     <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_mct_sequencer.sv
// tb_mct_sequencer: directed self-checking bench for mct_sequencer
module tb_mct_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, op_valid = 1'b0, extracode = 1'b0;
  logic irq_req = 1'b0, irq_inhibit = 1'b0;
  logic [2:0] op = 3'd0;
  logic op_ready, irq_ack, instr_done;
  logic [11:0] tp;
  logic [2:0] mct_idx;
  logic [1:0] seq_state;
  int errors = 0, checks = 0;
  int dn, dat, cyc;
  logic bad;

  mct_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .op_valid(op_valid), .op(op),
    .extracode(extracode), .op_ready(op_ready), .irq_req(irq_req),
    .irq_inhibit(irq_inhibit), .irq_ack(irq_ack), .tp(tp), .mct_idx(mct_idx),
    .seq_state(seq_state), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [2:0] o, input logic e);
    op = o; extracode = e; op_valid = 1'b1;
    tick(1);
  endtask

  initial begin
    // 1: reset and a single-MCT TC
    tick(2);
    chk("rst_state", seq_state, 0); chk("rst_tp", tp, 0); chk("rst_mct", mct_idx, 0);
    chk("rst_ready", op_ready, 1); chk("rst_ack", irq_ack, 0); chk("rst_done", instr_done, 0);
    rst_n = 1'b1; run = 1'b1;
    start(3'b000, 1'b0);
    op_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (tp !== (12'd1 << i) || (instr_done !== (i == 11)) || seq_state !== 2'd1) bad = 1'b1;
      if (i < 11) tick(1);
    end
    chk("tc_walk", bad, 0); chk("tc_done", instr_done, 1); chk("tc_ready", op_ready, 1);
    tick(1);
    chk("tc_idle_state", seq_state, 0); chk("tc_idle_tp", tp, 0);
    // 2: DV, 6 MCTs
    start(3'b001, 1'b1);
    op_valid = 1'b0; dn = 0; dat = 0;
    for (int c = 1; c <= 72; c++) begin
      if (instr_done) begin dn++; dat = c; end
      if (c == 13) chk("dv_mct1", mct_idx, 1);
      if (c == 72) chk("dv_mct5", mct_idx, 5);
      if (c < 72) tick(1);
    end
    chk("dv_done_cnt", dn, 1); chk("dv_done_at", dat, 72);
    tick(1);
    chk("dv_idle", seq_state, 0);
    // 3: AD then MP back to back; op change after accept must be ignored
    start(3'b110, 1'b0);
    op = 3'b111; extracode = 1'b1;
    tick(23);
    chk("ad_done", instr_done, 1); chk("ad_tp", tp, 12'h800); chk("ad_mct", mct_idx, 1);
    chk("ad_ready", op_ready, 1);
    tick(1);
    chk("mp_t01_tp", tp, 1); chk("mp_t01_mct", mct_idx, 0); chk("mp_t01_state", seq_state, 1);
    // 4: interrupt during MP, TC pending
    irq_req = 1'b1; op = 3'b000; extracode = 1'b0;
    tick(12);
    chk("mid_ack", irq_ack, 0); chk("mid_ready", op_ready, 0);
    tick(23);
    chk("mp_mct2", mct_idx, 2); chk("mp_ack", irq_ack, 1); chk("mp_ready", op_ready, 0);
    chk("mp_done", instr_done, 1);
    tick(1);
    chk("rupt_state", seq_state, 2); chk("rupt_tp", tp, 1); chk("rupt_ack_off", irq_ack, 0);
    bad = 1'b0;
    for (int c = 1; c < 24; c++) begin
      tick(1);
      if (instr_done !== 1'b0 || irq_ack !== 1'b0) bad = 1'b1;
    end
    chk("rupt_quiet", bad, 0); chk("rupt_end_mct", mct_idx, 1); chk("rupt_end_tp", tp, 12'h800);
    chk("rupt_no_chain", op_ready, 1);
    tick(1);
    irq_req = 1'b0; op_valid = 1'b0;
    chk("post_rupt_state", seq_state, 1); chk("post_rupt_tp", tp, 1);
    tick(11);
    chk("post_rupt_done", instr_done, 1);
    tick(1);
    chk("post_rupt_idle", seq_state, 0);
    // 4b: same with interrupts inhibited
    start(3'b111, 1'b1);
    irq_req = 1'b1; irq_inhibit = 1'b1; op = 3'b000; extracode = 1'b0;
    tick(35);
    chk("inh_ack", irq_ack, 0); chk("inh_ready", op_ready, 1); chk("inh_done", instr_done, 1);
    tick(1);
    op_valid = 1'b0; irq_req = 1'b0; irq_inhibit = 1'b0;
    chk("inh_next_state", seq_state, 1); chk("inh_next_tp", tp, 1);
    tick(12);
    chk("inh_idle", seq_state, 0);
    // 5: freeze DV at MCT1 T05 for 5 cycles
    start(3'b001, 1'b1);
    op_valid = 1'b0;
    tick(16);
    chk("frz_mct", mct_idx, 1); chk("frz_tp", tp, 12'h010);
    run = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (tp !== 12'h010 || mct_idx !== 3'd1 || seq_state !== 2'd1 || instr_done !== 1'b0) bad = 1'b1;
    end
    chk("frz_hold", bad, 0);
    run = 1'b1; cyc = 0;
    while (!instr_done && cyc < 100) begin tick(1); cyc++; end
    chk("frz_delay", cyc, 55);
    tick(1);
    chk("frz_idle", seq_state, 0);
    // 6: async reset mid-DV
    start(3'b001, 1'b1);
    op_valid = 1'b0;
    tick(42);
    chk("ar_pre_mct", mct_idx, 3); chk("ar_pre_tp", tp, 12'h040);
    rst_n = 1'b0;
    #1;
    chk("ar_state", seq_state, 0); chk("ar_tp", tp, 0); chk("ar_ready", op_ready, 1);
    chk("ar_mct", mct_idx, 0);
    #1 rst_n = 1'b1;
    op = 3'b000; extracode = 1'b0; op_valid = 1'b1;
    tick(1);
    op_valid = 1'b0;
    chk("ar_tc_t01", tp, 1);
    tick(11);
    chk("ar_tc_done", instr_done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
